// File: rtl/router_input_buffer.sv
// router_input_buffer: two independent FWFT lane FIFOs with back-pressure and sticky error flags
module router_input_lane #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4,
    parameter int CNT_W  = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              rd_i,
    output logic              full_o,
    output logic              valid_o,
    output logic [DATA_W-1:0] packet_o,
    output logic [CNT_W-1:0]  count_o,
    output logic              ovf_o,
    output logic              udf_o
);
    localparam int PTR_W = $clog2(DEPTH);
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              full_q, full_d, valid_q, valid_d, wr_ok, rd_ok;
    // full and valid are registered copies of the next count so upstream sees no read-to-full path
    always_comb begin
        wr_ok    = wr_i && !full_q;
        rd_ok    = rd_i && valid_q;
        wr_ptr_d = wr_ok ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = rd_ok ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d  = count_q + CNT_W'(wr_ok) - CNT_W'(rd_ok);
        full_d   = count_d == CNT_W'(DEPTH);
        valid_d  = count_d != '0;
    end
    // pointer, occupancy and flag state; reset empties the lane immediately
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            valid_q  <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            valid_q  <= valid_d;
        end
    end
    // storage needs no reset; the empty flag masks stale contents
    always_ff @(posedge clk) begin
        if (wr_ok) mem_q[wr_ptr_q] <= data_i;
    end
    assign full_o   = full_q;
    assign valid_o  = valid_q;
    assign count_o  = count_q;
    assign packet_o = valid_q ? mem_q[rd_ptr_q] : '0;
    assign ovf_o    = wr_i && full_q;
    assign udf_o    = rd_i && !valid_q;
endmodule

module router_input_buffer #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4,
    parameter int CNT_W  = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid_0,
    input  logic [DATA_W-1:0] in_data_0,
    input  logic              in_valid_1,
    input  logic [DATA_W-1:0] in_data_1,
    output logic              full_0,
    output logic              full_1,
    output logic [DATA_W-1:0] packet_0,
    output logic [DATA_W-1:0] packet_1,
    output logic              pkt_valid_0,
    output logic              pkt_valid_1,
    input  logic              pkt_rd_0,
    input  logic              pkt_rd_1,
    output logic [CNT_W-1:0]  count_0,
    output logic [CNT_W-1:0]  count_1,
    output logic              ovf_err,
    output logic              udf_err
);
    logic ovf_0, ovf_1, udf_0, udf_1, ovf_err_q, udf_err_q;
    router_input_lane #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) u_lane_0 (
        .clk(clk), .rst(rst), .wr_i(in_valid_0), .data_i(in_data_0), .rd_i(pkt_rd_0),
        .full_o(full_0), .valid_o(pkt_valid_0), .packet_o(packet_0), .count_o(count_0),
        .ovf_o(ovf_0), .udf_o(udf_0)
    );
    router_input_lane #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) u_lane_1 (
        .clk(clk), .rst(rst), .wr_i(in_valid_1), .data_i(in_data_1), .rd_i(pkt_rd_1),
        .full_o(full_1), .valid_o(pkt_valid_1), .packet_o(packet_1), .count_o(count_1),
        .ovf_o(ovf_1), .udf_o(udf_1)
    );
    // sticky error flags, cleared only by reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_err_q <= 1'b0;
            udf_err_q <= 1'b0;
        end else begin
            ovf_err_q <= ovf_err_q || ovf_0 || ovf_1;
            udf_err_q <= udf_err_q || udf_0 || udf_1;
        end
    end
    assign ovf_err = ovf_err_q;
    assign udf_err = udf_err_q;
endmodule
